// File: rtl/lot_counter_pkg.sv
// Shared types and constants for the parking-lot occupancy tracker.
package lot_pkg;

    localparam int LOT_CAPACITY = 25;
    localparam int LOT_WIDTH    = 5;

    // Synchronized sensor pair {a_s, b_s}; 1 means the beam is blocked.
    localparam logic [1:0] AB_NONE  = 2'b00;
    localparam logic [1:0] AB_INNER = 2'b01;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;

    // Direction detector states: E* walk the entry path, X* the exit path.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_E2   = 3'd2,
        ST_E3   = 3'd3,
        ST_X1   = 3'd4,
        ST_X2   = 3'd5,
        ST_X3   = 3'd6
    } lot_state_t;

endpackage

// File: rtl/lot_counter_if.sv
// Sensor inputs and occupancy outputs of the lot counter, bundled as one port.
interface lot_counter_if #(
    parameter int WIDTH = lot_pkg::LOT_WIDTH
);
    logic             a;
    logic             b;
    logic [WIDTH-1:0] num;
    logic             enter;
    logic             exit;
    logic             full;
    logic             empty;

    // master drives the sensors and watches the count; slave is the counter.
    modport master (
        output a,
        output b,
        input  num,
        input  enter,
        input  exit,
        input  full,
        input  empty
    );

    modport slave (
        input  a,
        input  b,
        output num,
        output enter,
        output exit,
        output full,
        output empty
    );
endinterface

// File: rtl/lot_counter_car_detect.sv
// Sensor synchronizer plus direction FSM: turns the two beam sensors into
// single-cycle enter/exit events. enter_next/exit_next are the unregistered
// events, so the counter can update on the same edge the pulses appear.
module car_detect
    import lot_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic enter_next,
    output logic exit_next
);

    logic [1:0] raw;
    logic [1:0] ab;

    assign raw = {a, b};

    // Two-flop synchronizer per sensor bit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;

            // Shift the raw sensor level through two flops.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign ab[gi] = sync2_reg;
        end
    endgenerate

    lot_state_t state_reg;
    lot_state_t state_next;
    logic       enter_reg;
    logic       exit_reg;

    // State register and registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            enter_reg <= 1'b0;
            exit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            enter_reg <= enter_next;
            exit_reg  <= exit_next;
        end
    end

    // Next-state decode; patterns not listed for a state leave it unchanged.
    always_comb begin
        state_next = state_reg;
        enter_next = 1'b0;
        exit_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ab == AB_OUTER)      state_next = ST_E1;
                else if (ab == AB_INNER) state_next = ST_X1;
            end
            ST_E1: begin
                if (ab == AB_BOTH)       state_next = ST_E2;
                else if (ab == AB_NONE)  state_next = ST_IDLE;
            end
            ST_E2: begin
                if (ab == AB_INNER)      state_next = ST_E3;
                else if (ab == AB_OUTER) state_next = ST_E1;
                else if (ab == AB_NONE)  state_next = ST_IDLE;
            end
            ST_E3: begin
                if (ab == AB_NONE) begin
                    state_next = ST_IDLE;
                    enter_next = 1'b1;
                end else if (ab == AB_BOTH) begin
                    state_next = ST_E2;
                end
            end
            ST_X1: begin
                if (ab == AB_BOTH)       state_next = ST_X2;
                else if (ab == AB_NONE)  state_next = ST_IDLE;
            end
            ST_X2: begin
                if (ab == AB_OUTER)      state_next = ST_X3;
                else if (ab == AB_INNER) state_next = ST_X1;
                else if (ab == AB_NONE)  state_next = ST_IDLE;
            end
            ST_X3: begin
                if (ab == AB_NONE) begin
                    state_next = ST_IDLE;
                    exit_next  = 1'b1;
                end else if (ab == AB_BOTH) begin
                    state_next = ST_X2;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter = enter_reg;
    assign exit  = exit_reg;

endmodule

// File: rtl/lot_counter.sv
// Parking-lot occupancy tracker: direction detector feeding a saturating
// occupancy counter with full/empty flags.
module lot_counter
    import lot_pkg::*;
#(
    parameter int CAPACITY = LOT_CAPACITY,
    parameter int WIDTH    = LOT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    lot_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic             enter_ev;
    logic             exit_ev;
    logic [WIDTH-1:0] num_reg;
    logic [WIDTH-1:0] num_next;

    car_detect u_detect (
        .clk        (clk),
        .reset      (reset),
        .a          (bus.a),
        .b          (bus.b),
        .enter      (bus.enter),
        .exit       (bus.exit),
        .enter_next (enter_ev),
        .exit_next  (exit_ev)
    );

    // Saturating count: events at the limits still pulse but leave num alone.
    always_comb begin
        num_next = num_reg;
        if (enter_ev && (num_reg < CAP_W)) begin
            num_next = num_reg + ONE_W;
        end else if (exit_ev && (num_reg != '0)) begin
            num_next = num_reg - ONE_W;
        end
    end

    // Occupancy register; reset wins over any event in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reg <= '0;
        end else begin
            num_reg <= num_next;
        end
    end

    assign bus.num   = num_reg;
    assign bus.full  = (num_reg == CAP_W);
    assign bus.empty = (num_reg == '0);

endmodule

// File: tb/tb_lot_counter.sv
// Scenario bench for lot_counter with an expected-pulse scoreboard.
module tb_lot_counter;
    import lot_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lot_counter_if #(.WIDTH(LOT_WIDTH)) bus ();

    lot_counter #(
        .CAPACITY (LOT_CAPACITY),
        .WIDTH    (LOT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit         is_enter;
        logic [4:0] num;
    } exp_t;

    exp_t       sb[$];
    int         pulse_cycles[$];
    int         total = 0;
    int         bad = 0;
    int         cycle = 0;
    logic [4:0] model_num = 5'd0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: every pulse is matched against the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (bus.enter || bus.exit)) begin
            total++;
            pulse_cycles.push_back(cycle);
            if (bus.enter && bus.exit) begin
                bad++;
                $display("FAIL both_pulses enter=%0b exit=%0b required one-hot", bus.enter, bus.exit);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse enter=%0b exit=%0b num=%0d required no pulse",
                         bus.enter, bus.exit, bus.num);
            end else begin
                e = sb.pop_front();
                if (bus.enter !== e.is_enter || bus.num !== e.num) begin
                    bad++;
                    $display("FAIL pulse got enter=%0b num=%0d required enter=%0b num=%0d",
                             bus.enter, bus.num, e.is_enter, e.num);
                end else begin
                    $display("pulse ok cycle=%0d %s num=%0d", cycle,
                             e.is_enter ? "enter" : "exit", bus.num);
                end
            end
        end
    end

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v < 5'd25) ? v + 5'd1 : v;
    endfunction

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v != 5'd0) ? v - 5'd1 : v;
    endfunction

    // Drive n patterns (first pattern in the most significant used pair),
    // each held for 'hold' clocks; ev 1/2 queues one enter/exit expectation.
    task automatic drive_seq(input logic [15:0] seq, input int n, input int hold, input int ev);
        if (ev == 1) begin
            model_num = sat_inc(model_num);
            sb.push_back('{1'b1, model_num});
        end else if (ev == 2) begin
            model_num = sat_dec(model_num);
            sb.push_back('{1'b0, model_num});
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {bus.a, bus.b} = seq[2*(n-1-i) +: 2];
            repeat (hold - 1) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.a = 1'b1;
        bus.b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.num !== 5'd0) begin bad++; $display("FAIL reset_num got=%0d required=0", bus.num); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b required=1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b required=0", bus.full); end
        total++; if (bus.enter !== 1'b0 || bus.exit !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got enter=%0b exit=%0b required 0 0", bus.enter, bus.exit);
        end
        total++; if (dut.u_detect.state_reg !== ST_IDLE) begin
            bad++; $display("FAIL reset_state got=%0d required=%0d", dut.u_detect.state_reg, ST_IDLE);
        end
        $display("reset checked num=%0d empty=%0b full=%0b", bus.num, bus.empty, bus.full);
        @(negedge clk);
        reset = 1'b0;
        bus.a = 1'b0;
        bus.b = 1'b0;
        model_num = 5'd0;
        settle();
    endtask

    task automatic test_entry();
        int enter_at = 0;
        logic empty_before = 1'b0;
        logic empty_at = 1'b1;
        drive_seq({10'd0, 2'b10, 2'b11, 2'b01}, 3, 3, 0);
        model_num = sat_inc(model_num);
        sb.push_back('{1'b1, model_num});
        @(negedge clk);
        {bus.a, bus.b} = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (k == 2) empty_before = bus.empty;
            if (bus.enter === 1'b1 && enter_at == 0) begin
                enter_at = k;
                empty_at = bus.empty;
            end
        end
        total++; if (enter_at != 3) begin bad++; $display("FAIL entry_latency got=%0d required=3", enter_at); end
        total++; if (empty_before !== 1'b1 || empty_at !== 1'b0) begin
            bad++; $display("FAIL entry_empty_edge got before=%0b at=%0b required 1 0", empty_before, empty_at);
        end
        settle();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL entry_drain got=%0d pending required=0", sb.size()); end
        total++; if (bus.num !== 5'd1) begin bad++; $display("FAIL entry_num got=%0d required=1", bus.num); end
        $display("entry done num=%0d", bus.num);
    endtask

    task automatic test_exit_underflow();
        for (int r = 0; r < 2; r++) begin
            drive_seq({8'd0, 2'b01, 2'b11, 2'b10, 2'b00}, 4, 3, 2);
            settle();
            total++; if (sb.size() != 0) begin bad++; $display("FAIL exit_drain%0d got=%0d pending required=0", r, sb.size()); end
            total++; if (bus.num !== 5'd0 || bus.empty !== 1'b1) begin
                bad++; $display("FAIL exit_num%0d got num=%0d empty=%0b required num=0 empty=1", r, bus.num, bus.empty);
            end
            $display("exit %0d done num=%0d", r, bus.num);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 26; i++) begin
            drive_seq({8'd0, 2'b10, 2'b11, 2'b01, 2'b00}, 4, 3, 1);
            settle();
            if (i == 24 || i == 25) begin
                total++; if (sb.size() != 0) begin bad++; $display("FAIL sat_drain%0d got=%0d pending required=0", i, sb.size()); end
                total++; if (bus.num !== 5'd25 || bus.full !== 1'b1) begin
                    bad++; $display("FAIL sat_num%0d got num=%0d full=%0b required num=25 full=1", i, bus.num, bus.full);
                end
            end
        end
        $display("saturation done num=%0d full=%0b", bus.num, bus.full);
    endtask

    task automatic test_backup_abort();
        logic [15:0] seqs[7];
        int          lens[7];
        int          evs[7];
        seqs[0] = {8'd0, 2'b10, 2'b11, 2'b10, 2'b00};               lens[0] = 4; evs[0] = 0;
        seqs[1] = {4'd0, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00}; lens[1] = 6; evs[1] = 1;
        seqs[2] = {6'd0, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};        lens[2] = 5; evs[2] = 0;
        seqs[3] = {4'd0, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00}; lens[3] = 6; evs[3] = 0;
        seqs[4] = {6'd0, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};        lens[4] = 5; evs[4] = 0;
        seqs[5] = {2'd0, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00}; lens[5] = 7; evs[5] = 1;
        seqs[6] = {4'd0, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00}; lens[6] = 6; evs[6] = 2;
        // Start from an empty lot so every count change is visible.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_num = 5'd0;
        for (int s = 0; s < 7; s++) begin
            drive_seq(seqs[s], lens[s], 3, evs[s]);
            settle();
            total++; if (sb.size() != 0 || bus.num !== model_num) begin
                bad++; $display("FAIL backup%0d got num=%0d pending=%0d required num=%0d pending=0",
                                s, bus.num, sb.size(), model_num);
            end
            $display("backup case %0d done num=%0d", s, bus.num);
        end
    endtask

    task automatic test_reset_mid();
        int pulses_before;
        pulses_before = pulse_cycles.size();
        drive_seq({12'd0, 2'b10, 2'b11}, 2, 3, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_num = 5'd0;
        drive_seq({12'd0, 2'b01, 2'b00}, 2, 3, 0);
        settle();
        total++; if (pulse_cycles.size() != pulses_before) begin
            bad++; $display("FAIL reset_mid_pulses got=%0d required=0", pulse_cycles.size() - pulses_before);
        end
        total++; if (bus.num !== 5'd0) begin bad++; $display("FAIL reset_mid_num got=%0d required=0", bus.num); end
        total++; if (dut.u_detect.state_reg !== ST_IDLE) begin
            bad++; $display("FAIL reset_mid_state got=%0d required=%0d", dut.u_detect.state_reg, ST_IDLE);
        end
        $display("reset mid-sequence done num=%0d", bus.num);
    endtask

    task automatic test_back_to_back();
        int n;
        model_num = sat_inc(model_num);
        sb.push_back('{1'b1, model_num});
        model_num = sat_inc(model_num);
        sb.push_back('{1'b1, model_num});
        drive_seq({2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 8, 1, 0);
        settle();
        total++; if (sb.size() != 0 || bus.num !== model_num) begin
            bad++; $display("FAIL b2b_count got num=%0d pending=%0d required num=%0d pending=0",
                            bus.num, sb.size(), model_num);
        end
        n = pulse_cycles.size();
        total++;
        if (n < 2) begin
            bad++; $display("FAIL b2b_gap got %0d pulses required 2", n);
        end else if (pulse_cycles[n-1] - pulse_cycles[n-2] != 4) begin
            bad++; $display("FAIL b2b_gap got=%0d required=4", pulse_cycles[n-1] - pulse_cycles[n-2]);
        end
        $display("back-to-back done num=%0d", bus.num);
    endtask

    initial begin
        bus.a = 1'b0;
        bus.b = 1'b0;
        test_reset();
        test_entry();
        test_exit_underflow();
        test_saturation();
        test_backup_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
